// File: rtl/spi_frame_arb.sv
// Round-robin arbiter and LSB-first SPI frame sequencer with bounded suspend stalls.
// Build macro SPI_ARB_PRIO_EN gives requester 0 absolute priority over the round-robin.
module spi_frame_arb #(
  parameter int unsigned NREQ      = 3,
  parameter logic [7:0]  START_HDR = 8'h01,
  parameter logic [7:0]  CFG_HDR   = 8'h02,
  parameter logic [7:0]  READ_HDR  = 8'h04,
  parameter int unsigned MAX_SUS   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    cmd,
  input  logic [8*NREQ-1:0]    wdata,
  input  logic                 hold_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic                 busy,
  output logic                 frame,
  output logic                 serial,
  output logic                 suspend
);

  localparam int unsigned PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0]  OP_START  = 2'b00;
  localparam logic [1:0]  OP_CFG    = 2'b01;
  localparam logic [1:0]  OP_ILL    = 2'b11;
  localparam logic [1:0]  MAX_SUS_C = 2'(MAX_SUS);
  localparam logic [3:0]  HDR_LAST  = 4'd8;
  localparam logic [3:0]  CFG_LAST  = 4'd8;
  localparam logic [3:0]  READ_LAST = 4'd10;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, HEAD, BODY, GAP} state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [PW-1:0]   r_ptr;
  logic [1:0]      r_sus_cnt;
  logic [1:0]      r_op;
  logic [7:0]      r_wd;
  logic [NREQ-1:0] r_win_oh;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_err;
  logic            r_busy;
  logic            r_frame;
  logic            r_serial;
  logic            r_suspend;

  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_win_oh;
  logic [1:0]      w_op;
  logic [7:0]      w_wd;
  logic [7:0]      w_hdr;
  logic [3:0]      w_body_last;
  logic            w_sus;

  // First asserted request at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = (int'(r_ptr) + i) % int'(NREQ);
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = PW'(idx);
      end
    end
    w_ptr_nxt = (w_win == LAST_IDX) ? '0 : w_win + PW'(1);
`ifdef SPI_ARB_PRIO_EN
    if (req[0]) begin
      w_found   = 1'b1;
      w_win     = '0;
      w_ptr_nxt = r_ptr;
    end
`endif
  end

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
    w_op            = cmd[2*int'(w_win) +: 2];
    w_wd            = wdata[8*int'(w_win) +: 8];
    case (r_op)
      OP_START: w_hdr = START_HDR;
      OP_CFG:   w_hdr = CFG_HDR;
      default:  w_hdr = READ_HDR;
    endcase
    w_body_last = (r_op == OP_CFG) ? CFG_LAST : READ_LAST;
    // A stall repeats the previous data cycle, so that cycle must itself be a counted data cycle.
    w_sus = hold_in && (r_sus_cnt < MAX_SUS_C) &&
            (((r_state == HEAD) && (r_cnt != 4'd0)) || (r_state == BODY));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_sus_cnt <= '0;
      r_op      <= OP_START;
      r_wd      <= '0;
      r_win_oh  <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_frame   <= 1'b0;
      r_serial  <= 1'b0;
      r_suspend <= 1'b0;
    end else begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_suspend <= 1'b0;
      r_sus_cnt <= '0;
      case (r_state)
        IDLE, GAP: begin
          r_state  <= IDLE;
          r_frame  <= 1'b0;
          r_serial <= 1'b0;
          r_busy   <= 1'b0;
          if (w_found) begin
            r_ptr    <= w_ptr_nxt;
            r_gnt    <= w_win_oh;
            r_win_oh <= w_win_oh;
            r_op     <= w_op;
            r_wd     <= w_wd;
            r_cnt    <= '0;
            if (w_op == OP_ILL) begin
              r_err <= 1'b1;
            end else begin
              r_state <= HEAD;
              r_frame <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        HEAD, BODY: begin
          if (w_sus) begin
            r_suspend <= 1'b1;
            r_sus_cnt <= r_sus_cnt + 2'd1;
          end else if ((r_state == HEAD) && (r_cnt != HDR_LAST)) begin
            r_cnt    <= r_cnt + 4'd1;
            r_serial <= w_hdr[r_cnt[2:0]];
          end else if ((r_state == HEAD) && (r_op != OP_START)) begin
            r_state  <= BODY;
            r_cnt    <= 4'd1;
            r_serial <= (r_op == OP_CFG) & r_wd[0];
          end else if ((r_state == BODY) && (r_cnt != w_body_last)) begin
            r_cnt    <= r_cnt + 4'd1;
            r_serial <= (r_op == OP_CFG) & r_wd[r_cnt[2:0]];
          end else begin
            r_state  <= GAP;
            r_frame  <= 1'b0;
            r_serial <= 1'b0;
            r_done   <= r_win_oh;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign err     = r_err;
  assign busy    = r_busy;
  assign frame   = r_frame;
  assign serial  = r_serial;
  assign suspend = r_suspend;

endmodule

// File: tb/tb_spi_frame_arb.sv
// Scoreboard bench for spi_frame_arb: expected frames are queued at request time and
// compared bit by bit as the link emits them.
module tb_spi_frame_arb;

  localparam int NREQ = 3;
  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_CFG   = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  typedef struct {
    logic [NREQ-1:0] oh;
    logic            illegal;
    int              len;
    logic [31:0]     bits;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [2*NREQ-1:0] cmd = '0;
  logic [8*NREQ-1:0] wdata = '0;
  logic              hold_in = 1'b0;
  logic [NREQ-1:0]   gnt, done;
  logic              err, busy, frame, serial, suspend;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t cur;
  bit   capturing = 1'b0;
  bit   b2b_mode = 1'b0;
  int   b2b_frames = 0;
  int   nhigh = 0;
  int   run = 0;
  int   max_run = 0;
  int   last_max_run = 0;
  int   low_run = 0;
  int   pend[NREQ];

  spi_frame_arb dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .wdata(wdata), .hold_in(hold_in),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .frame(frame), .serial(serial),
    .suspend(suspend)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input int who, input logic [1:0] op, input logic [7:0] wd);
    exp_t e;
    e.oh      = '0;
    e.oh[who] = 1'b1;
    e.illegal = (op == OP_ILL);
    e.bits    = '0;
    e.len     = 0;
    case (op)
      OP_START: begin e.bits[7:0] = 8'h01; e.len = 9; end
      OP_CFG:   begin e.bits[7:0] = 8'h02; e.bits[15:8] = wd; e.len = 17; end
      OP_READ:  begin e.bits[7:0] = 8'h04; e.len = 19; end
      default:  ;
    endcase
    return e;
  endfunction

  task automatic request(input int who, input logic [1:0] op, input logic [7:0] wd, input int n);
    cmd[2*who +: 2]   = op;
    wdata[8*who +: 8] = wd;
    pend[who]         = n;
    req[who]          = 1'b1;
  endtask

  task automatic expect_frame(input int who, input logic [1:0] op, input logic [7:0] wd);
    sb.push_back(mk_exp(who, op, wd));
  endtask

  task automatic wait_quiet(input int maxc);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((sb.size() != 0 || capturing || req != '0 || busy) && c < maxc);
    if (sb.size() != 0 || capturing || req != '0 || busy) check_eq("timeout_quiet", 32'(c), 32'(maxc + 1));
  endtask

  // Link monitor: pops the scoreboard on each grant and follows the frame to its end.
  initial begin
    exp_t e;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        capturing = 1'b0;
        low_run   = 0;
      end else begin
        if (gnt != '0) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_gnt", 32'(gnt), 32'h0);
          end else begin
            e = sb.pop_front();
            check_eq("gnt", 32'(gnt), 32'(e.oh));
            check_eq("err", 32'(err), 32'(e.illegal));
            if (e.illegal) begin
              check_eq("ill_frame", 32'(frame), 32'h0);
            end else begin
              check_eq("rise_frame", 32'(frame), 32'h1);
              check_eq("rise_serial", 32'(serial), 32'h0);
              check_eq("rise_busy", 32'(busy), 32'h1);
              check_eq("rise_sus", 32'(suspend), 32'h0);
              if (b2b_mode) begin
                if (b2b_frames > 0) check_eq("gap_len", 32'(low_run), 32'h1);
                b2b_frames++;
              end
              cur       = e;
              capturing = 1'b1;
              nhigh     = 1;
              run       = 0;
              max_run   = 0;
            end
          end
        end else if (capturing) begin
          if (frame) begin
            if (suspend) begin
              run++;
              if (run > max_run) max_run = run;
              check_eq("sus_run_le3", 32'(run <= 3), 32'h1);
            end else begin
              run = 0;
              if (nhigh >= cur.len) check_eq("frame_overrun", 32'(nhigh), 32'(cur.len - 1));
              else check_eq("serial", 32'(serial), 32'(cur.bits[nhigh-1]));
              nhigh++;
            end
          end else begin
            check_eq("frame_len", 32'(nhigh), 32'(cur.len));
            check_eq("done", 32'(done), 32'(cur.oh));
            check_eq("gap_busy", 32'(busy), 32'h1);
            check_eq("gap_sus", 32'(suspend), 32'h0);
            capturing    = 1'b0;
            last_max_run = max_run;
          end
        end else begin
          if (suspend) check_eq("sus_outside", 32'(suspend), 32'h0);
          if (done != '0) check_eq("stray_done", 32'(done), 32'h0);
        end
        if (err && gnt == '0) check_eq("stray_err", 32'(err), 32'h0);
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i]) begin
            pend[i]--;
            if (pend[i] <= 0) req[i] = 1'b0;
          end
        end
        low_run = frame ? 0 : low_run + 1;
      end
    end
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_frame", 32'(frame), 32'h0);
    check_eq("rst_serial", 32'(serial), 32'h0);
    check_eq("rst_suspend", 32'(suspend), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // Start frame from requester 1.
    expect_frame(1, OP_START, 8'h00);
    request(1, OP_START, 8'h00, 1);
    wait_quiet(100);

    // Config frame from requester 0.
    expect_frame(0, OP_CFG, 8'hC3);
    request(0, OP_CFG, 8'hC3, 1);
    wait_quiet(100);

    // Read frame from requester 2 under continuous back-pressure.
    expect_frame(2, OP_READ, 8'h00);
    request(2, OP_READ, 8'h00, 1);
    c = 0;
    while (!(capturing && nhigh >= 3) && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!(capturing && nhigh >= 3)) check_eq("timeout_bit2", 32'(c), 32'h0);
    hold_in = 1'b1;
    wait_quiet(300);
    check_eq("sus_max_run", 32'(last_max_run), 32'h3);
    repeat (4) @(negedge clk);
    hold_in = 1'b0;

    // All three requesters stream config frames back to back.
    b2b_mode = 1'b1;
`ifdef SPI_ARB_PRIO_EN
    expect_frame(0, OP_CFG, 8'h5A);
    expect_frame(0, OP_CFG, 8'h5A);
    expect_frame(1, OP_CFG, 8'hA5);
    expect_frame(2, OP_CFG, 8'h3C);
    expect_frame(1, OP_CFG, 8'hA5);
    expect_frame(2, OP_CFG, 8'h3C);
`else
    expect_frame(0, OP_CFG, 8'h5A);
    expect_frame(1, OP_CFG, 8'hA5);
    expect_frame(2, OP_CFG, 8'h3C);
    expect_frame(0, OP_CFG, 8'h5A);
    expect_frame(1, OP_CFG, 8'hA5);
    expect_frame(2, OP_CFG, 8'h3C);
`endif
    request(0, OP_CFG, 8'h5A, 2);
    request(1, OP_CFG, 8'hA5, 2);
    request(2, OP_CFG, 8'h3C, 2);
    wait_quiet(400);
    check_eq("b2b_frames", 32'(b2b_frames), 32'h6);
    b2b_mode = 1'b0;

    // Illegal opcode on requester 1, then requester 2 is served.
    expect_frame(1, OP_ILL, 8'h00);
    expect_frame(2, OP_CFG, 8'h96);
    request(1, OP_ILL, 8'h00, 1);
    request(2, OP_CFG, 8'h96, 1);
    wait_quiet(100);

    // Reset in the middle of a config header.
    expect_frame(0, OP_CFG, 8'hE7);
    request(0, OP_CFG, 8'hE7, 1);
    c = 0;
    while (!gnt[0] && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!gnt[0]) check_eq("timeout_gnt0", 32'(c), 32'h0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_frame", 32'(frame), 32'h0);
    check_eq("midrst_suspend", 32'(suspend), 32'h0);
    check_eq("midrst_busy", 32'(busy), 32'h0);
    check_eq("midrst_done", 32'(done), 32'h0);
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_no_done", 32'(done), 32'h0);
    end
    expect_frame(1, OP_CFG, 8'h3C);
    request(1, OP_CFG, 8'h3C, 1);
    wait_quiet(100);
    check_eq("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
